// File: rtl/filter_to_mem.sv
// filter_to_mem: filters a raster RGB565 stream per frame and writes every result pixel to the frame-buffer BRAM.
// The 3x3 window trails the input by IMG_W+1 pixels. FLUSH feeds zeros through the window to emit the last row.
module filter_to_mem #(
  parameter int IMG_W  = 480,
  parameter int IMG_H  = 272,
  parameter int ADDR_W = 17
) (
  input  logic              iClk,
  input  logic              iRst_n,
  input  logic              iPixValid,
  output logic              oPixReady,
  input  logic [15:0]       iPixData,
  input  logic              iSof,
  input  logic [1:0]        iMode,
  output logic              oWrEn,
  output logic [ADDR_W-1:0] oWrAddr,
  output logic [15:0]       oWrData,
  output logic              oFrameDone,
  output logic              oFrameErr
);

  localparam int N     = IMG_W * IMG_H;
  localparam int CNT_W = ADDR_W + 1;
  localparam int PTR_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int COL_W = $clog2(IMG_W + 1);
  localparam int ROW_W = $clog2(IMG_H + 1);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  state_t            state_q;
  logic              pixReady_q;
  logic [1:0]        mode_q;
  logic [CNT_W-1:0]  advCnt_q;
  logic [PTR_W-1:0]  ptr_q;
  logic [ADDR_W-1:0] outIdx_q;
  logic [COL_W-1:0]  outCol_q;
  logic [ROW_W-1:0]  outRow_q;
  logic [15:0]       win_q [3][3];
  logic              winValid_q, winLast_q, winBorder_q;
  logic [1:0]        winMode_q;
  logic [ADDR_W-1:0] winAddr_q;
  logic              wrEn_q, wrLast_q, frameDone_q, frameErr_q;
  logic [ADDR_W-1:0] wrAddr_q;
  logic [15:0]       wrData_q;

  logic [15:0] lineBuf1 [IMG_W];
  logic [15:0] lineBuf2 [IMG_W];

  logic             xfer, startFrame, abort, runAdv, flushAdv, advance, emit;
  logic [CNT_W-1:0] advIdx;
  logic [15:0]      advPix, lb1Rd, lb2Rd;

  always_comb begin
    xfer       = iPixValid && pixReady_q;
    startFrame = xfer && iSof;
    abort      = startFrame && (state_q == RUN);
    runAdv     = xfer && !iSof && (state_q == RUN);
    flushAdv   = (state_q == FLUSH);
    advance    = startFrame || runAdv || flushAdv;
    advIdx     = startFrame ? '0 : advCnt_q + CNT_W'(1);
    advPix     = flushAdv ? 16'h0000 : iPixData;
    emit       = advance && (advIdx >= CNT_W'(IMG_W + 1));
    lb1Rd      = lineBuf1[ptr_q];
    lb2Rd      = lineBuf2[ptr_q];
  end

  // Circular line buffers: each slot holds the pixel written IMG_W advances earlier.
  always_ff @(posedge iClk) begin
    if (advance) begin
      lineBuf1[ptr_q] <= advPix;
      lineBuf2[ptr_q] <= lb1Rd;
    end
  end

  logic [15:0] centre, grayPix, gaussPix, result_d;
  logic [5:0]  r6, g6, b6;
  logic [15:0] ySum;
  logic [5:0]  y6;
  logic [8:0]  accR, accB;
  logic [9:0]  accG;

  always_comb begin
    centre = win_q[1][1];
    r6     = {centre[4:0], centre[4]};
    g6     = centre[10:5];
    b6     = {centre[15:11], centre[15]};
    ySum   = 16'(r6) * 16'd77 + 16'(g6) * 16'd150 + 16'(b6) * 16'd29;
    y6     = 6'(ySum >> 8);
    grayPix = {y6[5:1], y6, y6[5:1]};
    accR = '0;
    accG = '0;
    accB = '0;
    // 1-2-1 kernel: each neighbour is shifted by how many of its coordinates are centred.
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        accR = accR + (9'(win_q[r][c][4:0])    << (((r == 1) ? 1 : 0) + ((c == 1) ? 1 : 0)));
        accG = accG + (10'(win_q[r][c][10:5])  << (((r == 1) ? 1 : 0) + ((c == 1) ? 1 : 0)));
        accB = accB + (9'(win_q[r][c][15:11])  << (((r == 1) ? 1 : 0) + ((c == 1) ? 1 : 0)));
      end
    end
    gaussPix = {5'(accB >> 4), 6'(accG >> 4), 5'(accR >> 4)};
    case (winMode_q)
      2'd0:    result_d = centre;
      2'd1:    result_d = grayPix;
      2'd2:    result_d = winBorder_q ? centre : gaussPix;
      default: result_d = ~centre;
    endcase
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state_q     <= IDLE;
      pixReady_q  <= 1'b1;
      mode_q      <= '0;
      advCnt_q    <= '0;
      ptr_q       <= '0;
      outIdx_q    <= '0;
      outCol_q    <= '0;
      outRow_q    <= '0;
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          win_q[r][c] <= '0;
      winValid_q  <= 1'b0;
      winLast_q   <= 1'b0;
      winBorder_q <= 1'b0;
      winMode_q   <= '0;
      winAddr_q   <= '0;
      wrEn_q      <= 1'b0;
      wrLast_q    <= 1'b0;
      wrAddr_q    <= '0;
      wrData_q    <= '0;
      frameDone_q <= 1'b0;
      frameErr_q  <= 1'b0;
    end else begin
      if (startFrame) mode_q <= iMode;
      if (advance) begin
        advCnt_q <= advIdx;
        ptr_q    <= (ptr_q == PTR_W'(IMG_W - 1)) ? '0 : ptr_q + PTR_W'(1);
        for (int r = 0; r < 3; r++) begin
          win_q[r][0] <= win_q[r][1];
          win_q[r][1] <= win_q[r][2];
        end
        win_q[0][2] <= lb2Rd;
        win_q[1][2] <= lb1Rd;
        win_q[2][2] <= advPix;
      end
      case (state_q)
        IDLE: if (startFrame) state_q <= RUN;
        RUN: begin
          if (runAdv && advIdx == CNT_W'(N - 1)) begin
            state_q    <= FLUSH;
            pixReady_q <= 1'b0;
          end
        end
        FLUSH: begin
          if (advIdx == CNT_W'(N + IMG_W)) begin
            state_q    <= IDLE;
            pixReady_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
      // Output coordinates are tracked incrementally so border detection needs no divider.
      if (startFrame) begin
        outIdx_q <= '0;
        outCol_q <= '0;
        outRow_q <= '0;
      end else if (emit) begin
        outIdx_q <= outIdx_q + ADDR_W'(1);
        if (outCol_q == COL_W'(IMG_W - 1)) begin
          outCol_q <= '0;
          outRow_q <= outRow_q + ROW_W'(1);
        end else begin
          outCol_q <= outCol_q + COL_W'(1);
        end
      end
      winValid_q <= emit;
      if (emit) begin
        winAddr_q   <= outIdx_q;
        winLast_q   <= (outIdx_q == ADDR_W'(N - 1));
        winMode_q   <= mode_q;
        winBorder_q <= (outRow_q == '0) || (outRow_q == ROW_W'(IMG_H - 1)) ||
                       (outCol_q == '0) || (outCol_q == COL_W'(IMG_W - 1));
      end
      wrEn_q   <= winValid_q && !abort;
      wrLast_q <= winValid_q && winLast_q && !abort;
      if (winValid_q) begin
        wrAddr_q <= winAddr_q;
        wrData_q <= result_d;
      end
      frameDone_q <= wrLast_q;
      frameErr_q  <= abort;
    end
  end

  assign oPixReady  = pixReady_q;
  assign oWrEn      = wrEn_q;
  assign oWrAddr    = wrAddr_q;
  assign oWrData    = wrData_q;
  assign oFrameDone = frameDone_q;
  assign oFrameErr  = frameErr_q;

endmodule
